// File: rtl/sa_pe_array_os.sv
// Output-stationary systolic MAC array: C = A x B, skewed operand injection,
// drain window, then one C row per handshake on the readout port.
module sa_pe_array_os #(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int ELEM_BITS = 8,
  parameter int ACC_BITS  = 32,
  parameter int KW        = 8,
  parameter int USE_DSP   = 0
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        start,
  input  logic [KW-1:0]               k_len,
  output logic                        busy,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ROWS*ELEM_BITS-1:0]   a_bus,
  input  logic [COLS*ELEM_BITS-1:0]   b_bus,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(ROWS)-1:0]     out_row_idx,
  output logic [COLS*ACC_BITS-1:0]    out_data,
  output logic                        done
);

  localparam int E  = ELEM_BITS;
  localparam int PW = 2 * ELEM_BITS;
  localparam int IW = $clog2(ROWS);
  localparam int DW = $clog2(ROWS + COLS) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t        state;
  logic [KW-1:0] kl;
  logic [KW-1:0] cnt;
  logic [DW-1:0] dcnt;

  logic feed;
  logic clr;

  assign feed = in_valid & in_ready;
  assign clr  = (state == S_IDLE) & start;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      kl          <= '0;
      cnt         <= '0;
      dcnt        <= '0;
      busy        <= 1'b0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_row_idx <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            kl          <= k_len;
            cnt         <= '0;
            busy        <= 1'b1;
            out_row_idx <= '0;
            if (k_len != '0) begin
              state    <= S_LOAD;
              in_ready <= 1'b1;
            end else begin
              state     <= S_OUT;
              out_valid <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            cnt <= cnt + KW'(1);
            if (cnt == kl - KW'(1)) begin
              state    <= S_DRAIN;
              in_ready <= 1'b0;
              dcnt     <= '0;
            end
          end
        end
        S_DRAIN: begin
          dcnt <= dcnt + DW'(1);
          if (dcnt == DW'(ROWS + COLS - 2)) begin
            state       <= S_OUT;
            out_valid   <= 1'b1;
            out_row_idx <= '0;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            if (out_row_idx == IW'(ROWS - 1)) begin
              state       <= S_IDLE;
              out_valid   <= 1'b0;
              out_row_idx <= '0;
              busy        <= 1'b0;
              done        <= 1'b1;
            end else begin
              out_row_idx <= out_row_idx + IW'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic signed [E-1:0]        a_lane [ROWS];
  logic signed [E-1:0]        b_lane [COLS];
  logic signed [E-1:0]        sa     [ROWS][ROWS];
  logic signed [E-1:0]        sb     [COLS][COLS];
  logic signed [E-1:0]        a_sk   [ROWS];
  logic signed [E-1:0]        b_sk   [COLS];
  logic signed [E-1:0]        a_in   [ROWS][COLS];
  logic signed [E-1:0]        b_in   [ROWS][COLS];
  logic signed [E-1:0]        a_r    [ROWS][COLS];
  logic signed [E-1:0]        b_r    [ROWS][COLS];
  logic signed [PW-1:0]       prod   [ROWS][COLS];
  logic signed [ACC_BITS-1:0] acc    [ROWS][COLS];

  // Lane i enters i cycles late so slice k meets at PE(i,j) on cycle k+i+j.
  always_comb begin
    for (int i = 0; i < ROWS; i++) a_lane[i] = a_bus[i*E +: E];
    for (int j = 0; j < COLS; j++) b_lane[j] = b_bus[j*E +: E];
    a_sk[0] = feed ? a_lane[0] : '0;
    b_sk[0] = feed ? b_lane[0] : '0;
    for (int i = 1; i < ROWS; i++) a_sk[i] = sa[i][i-1];
    for (int j = 1; j < COLS; j++) b_sk[j] = sb[j][j-1];
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        a_in[i][j] = (j == 0) ? a_sk[i] : a_r[i][j-1];
        b_in[i][j] = (i == 0) ? b_sk[j] : b_r[i-1][j];
      end
    end
  end

  generate
    if (USE_DSP != 0) begin : g_dsp
      (* use_dsp = "yes" *) logic signed [PW-1:0] dp [ROWS][COLS];
      always_comb begin
        for (int i = 0; i < ROWS; i++)
          for (int j = 0; j < COLS; j++)
            dp[i][j] = PW'(a_in[i][j]) * PW'(b_in[i][j]);
      end
      assign prod = dp;
    end else begin : g_lut
      always_comb begin
        for (int i = 0; i < ROWS; i++)
          for (int j = 0; j < COLS; j++)
            prod[i][j] = PW'(a_in[i][j]) * PW'(b_in[i][j]);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < ROWS; i++)
        for (int d = 0; d < ROWS; d++) sa[i][d] <= '0;
      for (int j = 0; j < COLS; j++)
        for (int d = 0; d < COLS; d++) sb[j][d] <= '0;
      for (int i = 0; i < ROWS; i++) begin
        for (int j = 0; j < COLS; j++) begin
          a_r[i][j] <= '0;
          b_r[i][j] <= '0;
          acc[i][j] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < ROWS; i++) begin
        sa[i][0] <= feed ? a_lane[i] : '0;
        for (int d = 1; d < ROWS; d++) sa[i][d] <= sa[i][d-1];
      end
      for (int j = 0; j < COLS; j++) begin
        sb[j][0] <= feed ? b_lane[j] : '0;
        for (int d = 1; d < COLS; d++) sb[j][d] <= sb[j][d-1];
      end
      for (int i = 0; i < ROWS; i++) begin
        for (int j = 0; j < COLS; j++) begin
          a_r[i][j] <= a_in[i][j];
          b_r[i][j] <= b_in[i][j];
          if (clr) acc[i][j] <= '0;
          else     acc[i][j] <= acc[i][j] + ACC_BITS'(prod[i][j]);
        end
      end
    end
  end

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      for (int j = 0; j < COLS; j++)
        out_data[j*ACC_BITS +: ACC_BITS] = acc[out_row_idx][j];
    end
  end

endmodule
